// File: rtl/rs_ctrl_pkg.sv
// Shared types and constants for the row-stationary scheduler.
// Holds the sequencer state encoding, buffer chip-select codes and default array geometry.
package rs_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_CONV   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [1:0] CS_IDLE   = 2'b00;
  localparam logic [1:0] CS_FMAPS  = 2'b01;
  localparam logic [1:0] CS_WEIGHT = 2'b10;

  localparam int DEF_FILT_W = 5;
  localparam int DEF_FMAP_W = 32;
  localparam int N_OUT      = DEF_FMAP_W - DEF_FILT_W + 1;

endpackage

// File: rtl/rs_delay_line.sv
// Fixed-depth shift register with synchronous flush.
// Aligns the array's window-complete flag and column index with the PE pipeline.
module rs_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift stages each cycle; flush empties the whole line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/rs_sched_ctrl.sv
// Row-stationary sequencer: preloads one filter, then streams fmaps windows into the PE array.
// Buffer lanes are registered from the next state; PE flags are the issue cycle registered once.
module rs_sched_ctrl
  import rs_ctrl_pkg::*;
#(
  parameter int FMAP_W      = DEF_FMAP_W,
  parameter int FILT_W      = DEF_FILT_W,
  parameter int FADDR_W     = 5,
  parameter int WADDR_W     = 6,
  parameter int W_BANK_BASE = 32,
  parameter int PE_LAT      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               weight_select,
  input  logic               abort,
  output logic [1:0]         cs,
  output logic [1:0]         we,
  output logic [FADDR_W-1:0] fmaps_addr,
  output logic [WADDR_W-1:0] weight_addr,
  output logic               w_load,
  output logic [2:0]         w_idx,
  output logic               pe_en,
  output logic               psum_clr,
  output logic               pe_last,
  output logic               acc_valid,
  output logic [FADDR_W-1:0] out_col,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0]         K_LAST     = 3'(FILT_W - 1);
  localparam logic [2:0]         DRAIN_LAST = 3'(PE_LAT);
  localparam logic [FADDR_W-1:0] O_LAST     = FADDR_W'(FMAP_W - FILT_W);
  localparam logic [WADDR_W-1:0] BANK1_BASE = WADDR_W'(W_BANK_BASE);
  localparam int                 DL_W       = FADDR_W + 1;

  state_e             state_r, state_s;
  logic [2:0]         k_r, k_s;
  logic [FADDR_W-1:0] o_r, o_s;
  logic               wsel_r, wsel_s;
  logic [1:0]         cs_r, cs_s;
  logic [FADDR_W-1:0] faddr_r, faddr_s;
  logic [WADDR_W-1:0] waddr_r, waddr_s;
  logic               busy_r, busy_s, done_r, done_s;
  logic               w_load_r, w_load_s;
  logic [2:0]         w_idx_r, w_idx_s;
  logic               pe_en_r, pe_en_s, psum_clr_r, psum_clr_s, pe_last_r, pe_last_s;
  logic [FADDR_W-1:0] pe_col_r, pe_col_s;
  logic [DL_W-1:0]    dl_out_s;

  // Next state and loop counters; k doubles as the drain cycle counter.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    o_s     = o_r;
    wsel_s  = wsel_r;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s = ST_LOAD_W;
            k_s     = 3'd0;
            wsel_s  = weight_select;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD_W: begin
          if (k_r == K_LAST) begin
            state_s = ST_CONV;
            k_s     = 3'd0;
            o_s     = {FADDR_W{1'b0}};
          end else begin
            k_s = k_r + 3'd1;
          end
        end
        ST_CONV: begin
          if (k_r == K_LAST) begin
            k_s = 3'd0;
            if (o_r == O_LAST) begin
              state_s = ST_DRAIN;
            end else begin
              o_s = o_r + {{(FADDR_W-1){1'b0}}, 1'b1};
            end
          end else begin
            k_s = k_r + 3'd1;
          end
        end
        ST_DRAIN: begin
          if (k_r == DRAIN_LAST) begin
            state_s = ST_DONE;
          end else begin
            k_s = k_r + 3'd1;
          end
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Buffer lanes for the coming cycle; addresses hold whenever nothing is issued.
  always_comb begin
    cs_s    = CS_IDLE;
    faddr_s = faddr_r;
    waddr_s = waddr_r;
    case (state_s)
      ST_LOAD_W: begin
        cs_s    = CS_WEIGHT;
        waddr_s = (wsel_s ? BANK1_BASE : {WADDR_W{1'b0}}) + WADDR_W'(k_s);
      end
      ST_CONV: begin
        cs_s    = CS_FMAPS;
        faddr_s = o_s + FADDR_W'(k_s);
      end
      default: cs_s = CS_IDLE;
    endcase
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_DONE);
  end

  // Array flags trail the issue cycle by the one-cycle buffer read latency.
  always_comb begin
    w_idx_s  = w_idx_r;
    pe_col_s = pe_col_r;
    if (!abort && state_r == ST_LOAD_W) begin
      w_load_s = 1'b1;
      w_idx_s  = k_r;
    end else begin
      w_load_s = 1'b0;
    end
    if (!abort && state_r == ST_CONV) begin
      pe_en_s    = 1'b1;
      psum_clr_s = (k_r == 3'd0);
      pe_last_s  = (k_r == K_LAST);
      pe_col_s   = o_r;
    end else begin
      pe_en_s    = 1'b0;
      psum_clr_s = 1'b0;
      pe_last_s  = 1'b0;
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      k_r        <= 3'd0;
      o_r        <= {FADDR_W{1'b0}};
      wsel_r     <= 1'b0;
      cs_r       <= CS_IDLE;
      faddr_r    <= {FADDR_W{1'b0}};
      waddr_r    <= {WADDR_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      w_load_r   <= 1'b0;
      w_idx_r    <= 3'd0;
      pe_en_r    <= 1'b0;
      psum_clr_r <= 1'b0;
      pe_last_r  <= 1'b0;
      pe_col_r   <= {FADDR_W{1'b0}};
    end else begin
      state_r    <= state_s;
      k_r        <= k_s;
      o_r        <= o_s;
      wsel_r     <= wsel_s;
      cs_r       <= cs_s;
      faddr_r    <= faddr_s;
      waddr_r    <= waddr_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      w_load_r   <= w_load_s;
      w_idx_r    <= w_idx_s;
      pe_en_r    <= pe_en_s;
      psum_clr_r <= psum_clr_s;
      pe_last_r  <= pe_last_s;
      pe_col_r   <= pe_col_s;
    end
  end

  rs_delay_line #(
    .WIDTH(DL_W),
    .DEPTH(PE_LAT)
  ) u_acc_align (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(abort),
    .din  ({pe_last_r, pe_col_r}),
    .dout (dl_out_s)
  );

  assign cs          = cs_r;
  assign we          = 2'b00;
  assign fmaps_addr  = faddr_r;
  assign weight_addr = waddr_r;
  assign w_load      = w_load_r;
  assign w_idx       = w_idx_r;
  assign pe_en       = pe_en_r;
  assign psum_clr    = psum_clr_r;
  assign pe_last     = pe_last_r;
  assign acc_valid   = dl_out_s[DL_W-1];
  assign out_col     = dl_out_s[FADDR_W-1:0];
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_rs_sched_ctrl.sv
// Scoreboard bench for rs_sched_ctrl: a run-level model schedules every expected
// buffer read and array event by absolute cycle; a negedge monitor consumes them.
module tb_rs_sched_ctrl;

  localparam int FMAP_W = 32, FILT_W = 5, PE_LAT = 2, BANK = 32;
  localparam int N_OUT  = FMAP_W - FILT_W + 1;
  localparam int RUN_LEN = FILT_W + N_OUT * FILT_W + PE_LAT + 1;  // done cycle, 148
  localparam int K_WRD = 0, K_WL = 1, K_FRD = 2, K_PE = 3, K_ACC = 4, K_DONE = 5;

  typedef struct {int kind; int t; int a; int b;} ev_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, weight_select = 1'b0, abort = 1'b0;
  logic [1:0] cs, we;
  logic [4:0] fmaps_addr, out_col;
  logic [5:0] weight_addr;
  logic [2:0] w_idx;
  logic w_load, pe_en, psum_clr, pe_last, acc_valid, busy, done;

  ev_t q[$];
  int cyc = 0, n_cmp = 0, n_err = 0;
  int busy_lo = 1, busy_hi = 0;

  rs_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .weight_select(weight_select), .abort(abort),
    .cs(cs), .we(we), .fmaps_addr(fmaps_addr), .weight_addr(weight_addr),
    .w_load(w_load), .w_idx(w_idx), .pe_en(pe_en), .psum_clr(psum_clr), .pe_last(pe_last),
    .acc_valid(acc_valid), .out_col(out_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int t, input int a, input int b);
    ev_t e;
    e.kind = kind; e.t = t; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  // Whole-run expectations from the schedule rules, first LOAD_W cycle = c0.
  task automatic model_run(input int c0, input bit ws);
    int t;
    for (int k = 0; k < FILT_W; k++) begin
      push(K_WRD, c0 + k, (ws ? BANK : 0) + k, 0);
      push(K_WL, c0 + 1 + k, k, 0);
    end
    for (int o = 0; o < N_OUT; o++) begin
      for (int k = 0; k < FILT_W; k++) begin
        t = c0 + FILT_W + o * FILT_W + k;
        push(K_FRD, t, o + k, 0);
        push(K_PE, t + 1, (k == 0) ? 1 : 0, (k == FILT_W - 1) ? 1 : 0);
        if (k == FILT_W - 1) push(K_ACC, t + 1 + PE_LAT, o, 0);
      end
    end
    push(K_DONE, c0 + RUN_LEN, 0, 0);
  endtask

  task automatic prune(input int tab);
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].t > tab) q.delete(i);
  endtask

  task automatic take(input int kind, input string nm, input int a, input int b);
    int idx;
    ev_t e;
    idx = -1;
    for (int i = 0; i < q.size(); i++) if (q[i].kind == kind) begin idx = i; break; end
    if (idx < 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s unexpected event cycle=%0d actual=%0d expected=none", nm, cyc, a);
    end else begin
      e = q[idx];
      q.delete(idx);
      chk({nm, "_cycle"}, cyc, e.t);
      chk({nm, "_a"}, a, e.a);
      chk({nm, "_b"}, b, e.b);
    end
  endtask

  // Monitor: consume one expectation per presented event, flag any overdue ones.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", int'(busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      chk("we", int'(we), 0);
      if (cs == 2'b11) chk("cs_both", int'(cs), 0);
      if (cs[1]) take(K_WRD, "wrd", int'(weight_addr), 0);
      if (cs[0]) take(K_FRD, "frd", int'(fmaps_addr), 0);
      if (w_load) take(K_WL, "wload", int'(w_idx), 0);
      if (pe_en) take(K_PE, "pe", int'(psum_clr), int'(pe_last));
      else if (psum_clr || pe_last) chk("pe_flags_idle", int'({psum_clr, pe_last}), 0);
      if (acc_valid) take(K_ACC, "acc", int'(out_col), 0);
      if (done) take(K_DONE, "done", 0, 0);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].t < cyc) begin
          n_cmp++; n_err++;
          $display("FAIL missing kind=%0d cycle=%0d actual=absent expected_at=%0d", q[i].kind, cyc, q[i].t);
          q.delete(i);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cs"}, int'(cs), 0);
    chk({tag, "_we"}, int'(we), 0);
    chk({tag, "_faddr"}, int'(fmaps_addr), 0);
    chk({tag, "_waddr"}, int'(weight_addr), 0);
    chk({tag, "_wload"}, int'(w_load), 0);
    chk({tag, "_widx"}, int'(w_idx), 0);
    chk({tag, "_pe"}, int'({pe_en, psum_clr, pe_last}), 0);
    chk({tag, "_acc"}, int'(acc_valid), 0);
    chk({tag, "_outcol"}, int'(out_col), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // One run with noise on start/weight_select; ab/rs give the abort/reset cycle or -1.
  task automatic run(input bit ws, input int ab, input int rs);
    int c0, cur;
    step();
    start = 1'b1; weight_select = ws;
    c0 = cyc + 1;
    model_run(c0, ws);
    busy_lo = c0; busy_hi = c0 + RUN_LEN;
    for (int n = 0; n < RUN_LEN + 4; n++) begin
      step();
      cur = cyc - c0;
      start = 1'b0;
      weight_select = 1'($urandom % 2);
      if (cur == ab) begin
        abort = 1'b1;
        prune(c0 + ab);
        busy_hi = c0 + ab;
        step();
        abort = 1'b0;
        break;
      end
      if (cur == rs) begin
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        q.delete();
        busy_hi = -1;
        step(); step();
        rst_n = 1'b1;
        break;
      end
      if (cur >= RUN_LEN) break;
      start = ($urandom % 5 == 0);
    end
    start = 1'b0;
    repeat (2 + $urandom % 3) step();
  endtask

  initial begin
    step(); step();
    check_zero("reset");
    rst_n = 1'b1;
    step();
    run(1'b0, -1, -1);
    run(1'b1, -1, -1);
    run(1'($urandom % 2), 50, -1);
    run(1'($urandom % 2), -1, -1);
    run(1'($urandom % 2), -1, 60);
    repeat (20) step();
    run(1'($urandom % 2), -1, -1);
    for (int r = 0; r < 3; r++)
      run(1'($urandom % 2), ($urandom % 2 == 0) ? int'($urandom_range(1, RUN_LEN - 1)) : -1, -1);
    repeat (5) step();
    chk("leftover_events", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rs_sched_ctrl.md
Name: rs_sched_ctrl

Overview:
Sequencer for the row-stationary PE array and its global buffer. On a start pulse it preloads one filter (5 weight columns from the selected weight bank), then streams fmaps columns as a sliding window. It drives the buffer's cs/we/address lanes and tells the array when to load weights, clear and accumulate partial sums, and when an output column is valid. It sits between the top-level start/weight_select control and the global_buffer/PE array pair.

Parameters:
FMAP_W, 32, fmaps columns per row (fmaps address space)
FILT_W, 5, filter width (weight columns per filter)
FADDR_W, 5, fmaps_addr width
WADDR_W, 6, weight_addr width
W_BANK_BASE, 32, weight_addr offset when weight_select=1 (bank 0 base = 0)
PE_LAT, 2, cycles from pe_last to acc_valid inside the PE array

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only in IDLE
weight_select  in  1  filter bank select, latched when start is accepted
abort  in  1  synchronous cancel, any state
cs  out  2  buffer chip selects: bit0 fmaps, bit1 weight
we  out  2  buffer write enables, held 2'b00 (read-only sequencer)
fmaps_addr  out  FADDR_W  fmaps column read address
weight_addr  out  WADDR_W  weight column read address
w_load  out  1  weight data on buffer outputs this cycle; PEs capture
w_idx  out  3  weight column index for w_load (0..FILT_W-1)
pe_en  out  1  fmaps data valid this cycle; PEs MAC
psum_clr  out  1  with pe_en: first tap of a window, PEs overwrite psum
pe_last  out  1  with pe_en: last tap of a window
acc_valid  out  1  acc from the array is a finished output column
out_col  out  FADDR_W  output column index qualified by acc_valid
busy  out  1  high from start acceptance to done (inclusive)
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; every output 0, including addresses, w_idx and out_col.
- Buffer read latency is 1 cycle: an address issued with cs in cycle t has data in t+1; w_load/pe_en/psum_clr/pe_last are the issue-cycle flags registered once.
- States: IDLE, LOAD_W, CONV, DRAIN, DONE.
- IDLE: start=1 -> latch weight_select into wsel, busy=1, go to LOAD_W. start in any other state is ignored.
- LOAD_W: FILT_W cycles, k=0..FILT_W-1: cs=2'b10, weight_addr = (wsel ? W_BANK_BASE : 0) + k. w_load=1 and w_idx=k in the next cycle. After k=FILT_W-1 -> CONV.
- CONV: o=0..FMAP_W-FILT_W (28 windows), k=0..FILT_W-1 inner: cs=2'b01, fmaps_addr=o+k. Next cycle: pe_en=1, psum_clr=(k==0), pe_last=(k==FILT_W-1). No bubbles between windows: 140 issue cycles. After o=27,k=4 -> DRAIN.
- acc_valid = pe_last delayed PE_LAT cycles; out_col = o delayed to align with it.
- DRAIN: PE_LAT+1 cycles with cs=0, until the last acc_valid is emitted -> DONE.
- DONE: done=1 for 1 cycle (busy still 1) -> IDLE; busy=0 the next cycle.
- cs=0 and addresses hold their last value whenever not issuing. fmaps_addr never exceeds FMAP_W-1; no wrap.
- abort=1 (any state, priority over everything, including start in IDLE): next state IDLE; cs, w_load, pe_en, psum_clr, pe_last, acc_valid and busy are 0 from the next cycle; delay line flushed; no done pulse.
- rst_n low mid-operation: immediate return to reset values.
- Total latency, with the first LOAD_W cycle as cycle 0: last issue cycle 144, final acc_valid cycle 147, done cycle 148.

Decomposition:
- Package rs_ctrl_pkg: state enum; CS_IDLE=2'b00, CS_FMAPS=2'b01, CS_WEIGHT=2'b10; FILT_W, FMAP_W defaults; N_OUT = FMAP_W-FILT_W+1.
- Sub-module rs_delay_line: WIDTH/DEPTH shift register with synchronous flush, used for the pe_last+out_col -> acc_valid/out_col alignment.

Test Plan:
- Reset: assert rst_n=0 mid-CONV -> all outputs 0 immediately; state IDLE after release; no done.
- weight_select=0, start: cycles 0..4 show cs=2'b10, weight_addr 0..4; w_load cycles 1..5 with w_idx 0..4. Repeat with weight_select=1 -> weight_addr 32..36.
- First window: cycles 5..9 show cs=2'b01, fmaps_addr 0..4; pe_en cycles 6..10; psum_clr only at cycle 6, pe_last only at 10; acc_valid at 12 with out_col=0.
- Full run: exactly 28 acc_valid pulses with out_col 0..27, spaced 5 cycles apart; last at cycle 147; done at 148 only; busy 0 at 149; max fmaps_addr = 31.
- start re-pulsed during CONV and weight_select toggled mid-run -> ignored; weight bank and timing are unchanged.
- abort at cycle 50 -> cs=0, pe_en=0, busy=0 from cycle 51; no further acc_valid; no done. A new start then runs a clean full sequence.
